// File: rtl/dbg_pkg.sv
// rtl/dbg_pkg.sv - shared types for the processor debug-port controller
package dbg_pkg;

    localparam int unsigned DBG_CNT_W = 5;

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_HALT    = 3'd1,
        OP_RESUME  = 3'd2,
        OP_EXEC    = 3'd3,
        OP_REG_RD  = 3'd4,
        OP_REG_WR  = 3'd5,
        OP_RESET   = 3'd6,
        OP_ILLEGAL = 3'd7
    } dbg_op_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DRAIN      = 3'd1,
        ST_EXEC_ISSUE = 3'd2,
        ST_REG_RD     = 3'd3,
        ST_REG_WR     = 3'd4,
        ST_RST_HOLD   = 3'd5,
        ST_INIT       = 3'd6,
        ST_RESP       = 3'd7
    } dbg_state_e;

    typedef struct packed {
        dbg_op_e     op;
        logic [4:0]  addr;
        logic [31:0] data;
    } dbg_cmd_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } dbg_rsp_t;

endpackage

// File: rtl/dbg_wait_counter.sv
// rtl/dbg_wait_counter.sv - loadable down-counter with zero flag for drain and reset holds
module dbg_wait_counter
    import dbg_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [DBG_CNT_W-1:0] load_val_i,
    input  logic                 en_i,
    output logic                 zero_o
);

    logic [DBG_CNT_W-1:0] cnt_q;
    logic [DBG_CNT_W-1:0] cnt_d;

    // Load wins over decrement; the count saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/debug_controller.sv
// rtl/debug_controller.sv - host command sequencer driving the processor debug port
module debug_controller
    import dbg_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 5,
    parameter int unsigned RST_CYCLES   = 4
) (
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iCmd_valid,
    output logic        oCmd_ready,
    input  logic [2:0]  iCmd_op,
    input  logic [4:0]  iCmd_addr,
    input  logic [31:0] iCmd_data,
    output logic        oRsp_valid,
    input  logic        iRsp_ready,
    output logic [31:0] oRsp_data,
    output logic        oRsp_err,
    output logic        oDBG_nRst,
    output logic        oDBG_halt,
    output logic        oDBG_exec,
    output logic        oDBG_req_init,
    output logic        oDBG_regWrite,
    output logic [31:0] oDBG_ins,
    output logic [4:0]  oDBG_rdAddr,
    output logic [31:0] oDBG_rdValue,
    output logic [4:0]  oDBG_rsAddr,
    input  logic [31:0] iDBG_rsValue
);

    // The counter runs from N-1 down to 0, so the wait state lasts N cycles.
    localparam logic [DBG_CNT_W-1:0] DRAIN_LOAD = DBG_CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [DBG_CNT_W-1:0] RST_LOAD   = DBG_CNT_W'(RST_CYCLES - 1);

    dbg_state_e  state_q, state_d;
    logic        halted_q, halted_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    dbg_rsp_t    rsp_q, rsp_d;

    dbg_cmd_t              cmd_in;
    logic                  cnt_load;
    logic [DBG_CNT_W-1:0]  cnt_load_val;
    logic                  cnt_en;
    logic                  cnt_zero;

    assign cmd_in = '{op: dbg_op_e'(iCmd_op), addr: iCmd_addr, data: iCmd_data};

    dbg_wait_counter u_wait (
        .clk_i      (iClk),
        .rst_ni     (nRst),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    // Next-state logic: command decode in IDLE, then op sequencing until RESP.
    always_comb begin
        state_d      = state_q;
        halted_d     = halted_q;
        addr_d       = addr_q;
        data_d       = data_q;
        rsp_d        = rsp_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (iCmd_valid) begin
                    addr_d  = cmd_in.addr;
                    data_d  = cmd_in.data;
                    rsp_d   = '0;
                    state_d = ST_RESP;
                    case (cmd_in.op)
                        OP_NOP: begin
                        end
                        OP_HALT: begin
                            // A redundant HALT answers at once without re-draining.
                            if (!halted_q) begin
                                halted_d     = 1'b1;
                                cnt_load     = 1'b1;
                                cnt_load_val = DRAIN_LOAD;
                                state_d      = ST_DRAIN;
                            end
                        end
                        OP_RESUME: begin
                            halted_d = 1'b0;
                        end
                        OP_EXEC: begin
                            if (halted_q) state_d = ST_EXEC_ISSUE;
                            else          rsp_d.err = 1'b1;
                        end
                        OP_REG_RD: begin
                            if (halted_q) state_d = ST_REG_RD;
                            else          rsp_d.err = 1'b1;
                        end
                        OP_REG_WR: begin
                            if (halted_q) state_d = ST_REG_WR;
                            else          rsp_d.err = 1'b1;
                        end
                        OP_RESET: begin
                            cnt_load     = 1'b1;
                            cnt_load_val = RST_LOAD;
                            state_d      = ST_RST_HOLD;
                        end
                        default: begin
                            rsp_d.err = 1'b1;
                        end
                    endcase
                end
            end
            ST_DRAIN: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_d = ST_RESP;
            end
            ST_EXEC_ISSUE: begin
                cnt_load     = 1'b1;
                cnt_load_val = DRAIN_LOAD;
                state_d      = ST_DRAIN;
            end
            ST_REG_RD: begin
                rsp_d.data = iDBG_rsValue;
                state_d    = ST_RESP;
            end
            ST_REG_WR: begin
                state_d = ST_RESP;
            end
            ST_RST_HOLD: begin
                cnt_en = 1'b1;
                if (cnt_zero) state_d = ST_INIT;
            end
            ST_INIT: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (iRsp_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, halted flag, latched command fields and response payload.
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ST_IDLE;
            halted_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rsp_q    <= rsp_d;
        end
    end

    // Debug-port strobes decode directly from the current state.
    always_comb begin
        oCmd_ready    = 1'b0;
        oRsp_valid    = 1'b0;
        oDBG_nRst     = 1'b1;
        oDBG_exec     = 1'b0;
        oDBG_req_init = 1'b0;
        oDBG_regWrite = 1'b0;
        case (state_q)
            ST_IDLE:       oCmd_ready    = 1'b1;
            ST_EXEC_ISSUE: oDBG_exec     = 1'b1;
            ST_REG_WR:     oDBG_regWrite = 1'b1;
            ST_RST_HOLD:   oDBG_nRst     = 1'b0;
            ST_INIT:       oDBG_req_init = 1'b1;
            ST_RESP:       oRsp_valid    = 1'b1;
            default: begin
            end
        endcase
    end

    assign oDBG_halt    = halted_q;
    assign oDBG_ins     = data_q;
    assign oDBG_rdValue = data_q;
    assign oDBG_rdAddr  = addr_q;
    assign oDBG_rsAddr  = addr_q;
    assign oRsp_data    = rsp_q.data;
    assign oRsp_err     = rsp_q.err;

endmodule

// File: tb/tb_debug_controller.sv
// tb/tb_debug_controller.sv - self-checking bench for debug_controller
module tb_debug_controller;

    localparam int D  = 5;
    localparam int RC = 4;

    logic        iClk, nRst;
    logic        iCmd_valid, oCmd_ready;
    logic [2:0]  iCmd_op;
    logic [4:0]  iCmd_addr;
    logic [31:0] iCmd_data;
    logic        oRsp_valid, iRsp_ready;
    logic [31:0] oRsp_data;
    logic        oRsp_err;
    logic        oDBG_nRst, oDBG_halt, oDBG_exec, oDBG_req_init, oDBG_regWrite;
    logic [31:0] oDBG_ins, oDBG_rdValue, iDBG_rsValue;
    logic [4:0]  oDBG_rdAddr, oDBG_rsAddr;

    debug_controller #(.DRAIN_CYCLES(D), .RST_CYCLES(RC)) dut (
        .iClk(iClk), .nRst(nRst),
        .iCmd_valid(iCmd_valid), .oCmd_ready(oCmd_ready),
        .iCmd_op(iCmd_op), .iCmd_addr(iCmd_addr), .iCmd_data(iCmd_data),
        .oRsp_valid(oRsp_valid), .iRsp_ready(iRsp_ready),
        .oRsp_data(oRsp_data), .oRsp_err(oRsp_err),
        .oDBG_nRst(oDBG_nRst), .oDBG_halt(oDBG_halt), .oDBG_exec(oDBG_exec),
        .oDBG_req_init(oDBG_req_init), .oDBG_regWrite(oDBG_regWrite),
        .oDBG_ins(oDBG_ins), .oDBG_rdAddr(oDBG_rdAddr), .oDBG_rdValue(oDBG_rdValue),
        .oDBG_rsAddr(oDBG_rsAddr), .iDBG_rsValue(iDBG_rsValue)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tcyc     = 0;

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;
    always @(posedge iClk) tcyc++;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, tcyc, act, exp);
        end
    endtask

    // Processor register file seen by the DUT
    logic [31:0] rf [32];
    assign iDBG_rsValue = rf[oDBG_rsAddr];
    always @(posedge iClk) if (oDBG_regWrite) rf[oDBG_rdAddr] <= oDBG_rdValue;

    // Behavioural model: command timeline in absolute cycles
    logic [31:0] m_rf [32];
    bit          m_idle, m_halted, m_err;
    logic [4:0]  m_addr;
    logic [31:0] m_data, m_rdata;
    int m_rsp, m_exec, m_wr, m_init, m_rlo, m_rhi;

    int exec_cnt, wr_cnt, init_cnt, nrst_lo_cnt, exec_last;

    task automatic model_reset();
        m_idle = 1; m_halted = 0; m_err = 0;
        m_addr = '0; m_data = '0; m_rdata = '0;
        m_rsp = -1; m_exec = -1; m_wr = -1; m_init = -1; m_rlo = -1; m_rhi = -2;
    endtask

    always @(negedge iClk) begin
        bit exp_rv;
        if (!nRst) model_reset();
        exp_rv = !m_idle && (tcyc >= m_rsp);
        check("cmd_ready", oCmd_ready, m_idle);
        check("rsp_valid", oRsp_valid, exp_rv);
        check("dbg_halt", oDBG_halt, m_halted);
        check("dbg_exec", oDBG_exec, tcyc == m_exec);
        check("dbg_regwrite", oDBG_regWrite, tcyc == m_wr);
        check("dbg_req_init", oDBG_req_init, tcyc == m_init);
        check("dbg_nrst", oDBG_nRst, !(tcyc >= m_rlo && tcyc <= m_rhi));
        check("dbg_ins", oDBG_ins, m_data);
        check("dbg_rdvalue", oDBG_rdValue, m_data);
        check("dbg_rdaddr", oDBG_rdAddr, m_addr);
        check("dbg_rsaddr", oDBG_rsAddr, m_addr);
        if (exp_rv) begin
            check("rsp_data", oRsp_data, m_rdata);
            check("rsp_err", oRsp_err, m_err);
        end
        if (oDBG_exec) begin exec_cnt++; exec_last = tcyc; end
        if (oDBG_regWrite) wr_cnt++;
        if (oDBG_req_init) init_cnt++;
        if (!oDBG_nRst) nrst_lo_cnt++;
        if (nRst) begin
            if (m_idle && iCmd_valid) begin
                m_idle = 0; m_err = 0; m_rdata = '0;
                m_addr = iCmd_addr; m_data = iCmd_data;
                m_rsp = tcyc + 1;
                case (iCmd_op)
                    3'd0: ;
                    3'd1: if (!m_halted) begin m_halted = 1; m_rsp = tcyc + 1 + D; end
                    3'd2: m_halted = 0;
                    3'd3: if (m_halted) begin m_exec = tcyc + 1; m_rsp = tcyc + 2 + D; end
                          else m_err = 1;
                    3'd4: if (m_halted) begin m_rdata = m_rf[iCmd_addr]; m_rsp = tcyc + 2; end
                          else m_err = 1;
                    3'd5: if (m_halted) begin
                              m_wr = tcyc + 1; m_rsp = tcyc + 2; m_rf[iCmd_addr] = iCmd_data;
                          end else m_err = 1;
                    3'd6: begin
                        m_rlo = tcyc + 1; m_rhi = tcyc + RC;
                        m_init = tcyc + RC + 1; m_rsp = tcyc + RC + 2;
                    end
                    default: m_err = 1;
                endcase
            end else if (exp_rv && iRsp_ready) begin
                m_idle = 1;
            end
        end
    end

    task automatic run_cmd(input logic [2:0] op, input logic [4:0] addr, input logic [31:0] data,
                           input int hold, input logic exp_err, input logic [31:0] exp_rdata,
                           input int exp_lat, output int rc);
        int acc;
        bit got;
        acc = 0; rc = 0;
        @(posedge iClk); #2;
        iCmd_valid = 1; iCmd_op = op; iCmd_addr = addr; iCmd_data = data;
        got = 0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge iClk);
            if (oCmd_ready) begin got = 1; acc = tcyc; end
        end
        check("accept_seen", got, 1);
        @(posedge iClk); #2;
        iCmd_valid = 0;
        iRsp_ready = (hold == 0);
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge iClk);
            if (oRsp_valid) begin got = 1; rc = tcyc; end
        end
        check("rsp_seen", got, 1);
        if (got) begin
            check("rsp_latency", rc - acc, exp_lat);
            check("rsp_err_lit", oRsp_err, exp_err);
            check("rsp_data_lit", oRsp_data, exp_rdata);
        end
        if (hold > 0) begin
            repeat (hold) @(posedge iClk);
            #2 iRsp_ready = 1;
        end
        @(posedge iClk); #2;
        iRsp_ready = 0;
    endtask

    initial begin
        int rc, e0, w0, i0, n0;
        for (int i = 0; i < 32; i++) begin
            rf[i]   = 32'h0101_0101 * i;
            m_rf[i] = 32'h0101_0101 * i;
        end
        model_reset();
        exec_cnt = 0; wr_cnt = 0; init_cnt = 0; nrst_lo_cnt = 0; exec_last = 0;
        nRst = 0; iCmd_valid = 0; iCmd_op = 0; iCmd_addr = 0; iCmd_data = 0; iRsp_ready = 0;
        #12;
        check("reset_cmd_ready", oCmd_ready, 1);
        check("reset_dbg_nrst", oDBG_nRst, 1);
        check("reset_rsp_valid", oRsp_valid, 0);
        check("reset_halt", oDBG_halt, 0);
        #10 nRst = 1;

        // errors and NOP, no strobes expected
        e0 = exec_cnt; w0 = wr_cnt;
        run_cmd(3'd4, 5'd3, 32'h0, 0, 1'b1, 32'h0, 1, rc);
        run_cmd(3'd7, 5'd1, 32'h1234, 0, 1'b1, 32'h0, 1, rc);
        check("err_no_exec", exec_cnt - e0, 0);
        check("err_no_regwrite", wr_cnt - w0, 0);
        run_cmd(3'd0, 5'd0, 32'h0, 0, 1'b0, 32'h0, 1, rc);

        // HALT drains for D cycles
        run_cmd(3'd1, 5'd0, 32'h0, 0, 1'b0, 32'h0, 6, rc);
        check("halt_flag", oDBG_halt, 1);

        // register write then read back
        w0 = wr_cnt;
        run_cmd(3'd5, 5'd5, 32'hDEADBEEF, 0, 1'b0, 32'h0, 2, rc);
        check("regwrite_pulses", wr_cnt - w0, 1);
        run_cmd(3'd4, 5'd5, 32'h0, 0, 1'b0, 32'hDEADBEEF, 2, rc);
        run_cmd(3'd4, 5'd7, 32'h0, 0, 1'b0, 32'h0707_0707, 2, rc);

        // instruction injection
        e0 = exec_cnt;
        run_cmd(3'd3, 5'd0, 32'h00100093, 0, 1'b0, 32'h0, 7, rc);
        check("exec_pulses", exec_cnt - e0, 1);
        check("exec_to_rsp", rc - exec_last, 6);
        check("exec_ins_held", oDBG_ins, 32'h00100093);

        // core reset keeps halted flag
        i0 = init_cnt; n0 = nrst_lo_cnt;
        run_cmd(3'd6, 5'd0, 32'h0, 0, 1'b0, 32'h0, 6, rc);
        check("rst_low_cycles", nrst_lo_cnt - n0, 4);
        check("init_pulses", init_cnt - i0, 1);
        check("rst_keeps_halt", oDBG_halt, 1);

        // slow host: response held for 7 cycles
        run_cmd(3'd0, 5'd0, 32'h0, 7, 1'b0, 32'h0, 1, rc);

        run_cmd(3'd2, 5'd0, 32'h0, 0, 1'b0, 32'h0, 1, rc);
        check("resume_flag", oDBG_halt, 0);
        run_cmd(3'd3, 5'd0, 32'h13, 0, 1'b1, 32'h0, 1, rc);

        // reset in the middle of a HALT drain
        @(posedge iClk); #2;
        iCmd_valid = 1; iCmd_op = 3'd1; iCmd_addr = 0; iCmd_data = 32'hA5;
        @(negedge iClk);
        check("mid_accept_ready", oCmd_ready, 1);
        @(posedge iClk); #2;
        iCmd_valid = 0;
        @(posedge iClk); @(posedge iClk); #2;
        check("mid_in_drain_halt", oDBG_halt, 1);
        nRst = 0;
        #1;
        check("async_halt", oDBG_halt, 0);
        check("async_ready", oCmd_ready, 1);
        check("async_rsp_valid", oRsp_valid, 0);
        check("async_ins", oDBG_ins, 0);
        repeat (2) @(posedge iClk);
        #2 nRst = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge iClk);
            check("no_rsp_after_reset", oRsp_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
